// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM pipeline stage; drives the SRAM-like data bus for
//                loads/stores and forms the MEM/WB write-back payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic                  ex_wreg_i,
    input  logic [2*DATA_W-1:0]   ex_wdata_i,
    input  logic [3:0]            ex_memop_i,
    input  logic [ADDR_W-1:0]     ex_memaddr_i,
    input  logic [DATA_W-1:0]     ex_storedata_i,
    output logic                  data_req_o,
    output logic                  data_wr_o,
    output logic [1:0]            data_size_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [DATA_W-1:0]     data_wdata_o,
    input  logic                  data_addr_ok_i,
    input  logic                  data_data_ok_i,
    input  logic [DATA_W-1:0]     data_rdata_i,
    output logic [REG_ADDR_W-1:0] mem_wd_o,
    output logic                  mem_wreg_o,
    output logic [2*DATA_W-1:0]   mem_wdata_o,
    output logic                  stall_req_o,
    output logic                  adel_o,
    output logic                  ades_o
);

    localparam int c_LANES  = DATA_W / 8;
    localparam int c_HALVES = DATA_W / 16;
    localparam int c_LANE_W = $clog2(c_LANES);

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LBU = 4'd2;
    localparam logic [3:0] c_OP_LH  = 4'd3;
    localparam logic [3:0] c_OP_LHU = 4'd4;
    localparam logic [3:0] c_OP_LW  = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;

    localparam logic [1:0] c_SIZE_B = 2'd0;
    localparam logic [1:0] c_SIZE_H = 2'd1;
    localparam logic [1:0] c_SIZE_W = 2'd2;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ADDR   = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_DONE   = 3'd3;
    localparam logic [2:0] c_CANCEL = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [DATA_W-1:0] r_rdata_q;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_signed;
    logic [1:0]        w_size;
    logic              w_misaligned;
    logic              w_access;
    logic              w_req;
    logic              w_stall;
    logic              w_out_en;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_ext;
    logic [DATA_W-1:0] w_store_data;

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = c_SIZE_W;
        case (ex_memop_i)
            c_OP_LB:  begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = c_SIZE_B; end
            c_OP_LBU: begin w_is_load  = 1'b1;                  w_size = c_SIZE_B; end
            c_OP_LH:  begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = c_SIZE_H; end
            c_OP_LHU: begin w_is_load  = 1'b1;                  w_size = c_SIZE_H; end
            c_OP_LW:  begin w_is_load  = 1'b1;                  w_size = c_SIZE_W; end
            c_OP_SB:  begin w_is_store = 1'b1;                  w_size = c_SIZE_B; end
            c_OP_SH:  begin w_is_store = 1'b1;                  w_size = c_SIZE_H; end
            c_OP_SW:  begin w_is_store = 1'b1;                  w_size = c_SIZE_W; end
            default:  ;
        endcase
    end

    assign w_misaligned = (w_is_load | w_is_store) &
                          (((w_size == c_SIZE_H) & ex_memaddr_i[0]) |
                           ((w_size == c_SIZE_W) & (ex_memaddr_i[1:0] != 2'b00)));
    assign w_access     = (w_is_load | w_is_store) & ~w_misaligned;

    // ------------------------------------------------ load lane extraction
    always_comb begin
        w_byte = '0;
        for (int i = 0; i < c_LANES; i++) begin
            if (ex_memaddr_i[c_LANE_W-1:0] == c_LANE_W'(i))
                w_byte = data_rdata_i[i*8 +: 8];
        end
        w_half = '0;
        for (int i = 0; i < c_HALVES; i++) begin
            if (ex_memaddr_i[c_LANE_W-1:1] == (c_LANE_W-1)'(i))
                w_half = data_rdata_i[i*16 +: 16];
        end
    end

    always_comb begin
        case (w_size)
            c_SIZE_B: w_load_ext = {{(DATA_W-8){w_signed & w_byte[7]}}, w_byte};
            c_SIZE_H: w_load_ext = {{(DATA_W-16){w_signed & w_half[15]}}, w_half};
            default:  w_load_ext = data_rdata_i;
        endcase
    end

    // Narrow stores are replicated across every lane so the bus can pick any.
    always_comb begin
        case (w_size)
            c_SIZE_B: w_store_data = {c_LANES{ex_storedata_i[7:0]}};
            c_SIZE_H: w_store_data = {c_HALVES{ex_storedata_i[15:0]}};
            default:  w_store_data = ex_storedata_i;
        endcase
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= c_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_rdata_q <= '0;
        else if ((r_state == c_DATA) && data_data_ok_i)
            r_rdata_q <= w_load_ext;
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_access && !flush_i)
                    w_next_state = data_addr_ok_i ? c_DATA : c_ADDR;
            end
            c_ADDR: begin
                if (flush_i)
                    w_next_state = c_IDLE;
                else if (data_addr_ok_i)
                    w_next_state = c_DATA;
            end
            c_DATA: begin
                // A flush racing data_ok has nothing left to wait for.
                if (data_data_ok_i)
                    w_next_state = flush_i ? c_IDLE : c_DONE;
                else if (flush_i)
                    w_next_state = c_CANCEL;
            end
            c_DONE: begin
                if (flush_i || !stall_i)
                    w_next_state = c_IDLE;
            end
            c_CANCEL: begin
                if (data_data_ok_i)
                    w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------------------------------------------------- state outputs
    always_comb begin
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_access && !flush_i) begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                end
            end
            c_ADDR: begin
                w_req   = ~flush_i;
                w_stall = 1'b1;
            end
            c_DATA:   w_stall = 1'b1;
            c_CANCEL: w_stall = 1'b1;
            default:  ;
        endcase
    end

    // Every output is forced low while reset is held.
    assign w_out_en     = ~rst_i;

    assign data_req_o   = w_out_en & w_req;
    assign data_wr_o    = w_out_en & w_is_store;
    assign data_size_o  = w_out_en ? w_size : 2'b00;
    assign data_addr_o  = w_out_en ? ex_memaddr_i : '0;
    assign data_wdata_o = w_out_en ? w_store_data : '0;

    assign mem_wd_o     = w_out_en ? ex_wd_i : '0;
    assign mem_wreg_o   = w_out_en & ex_wreg_i & ~w_misaligned & ~flush_i &
                          (~w_is_load | (r_state == c_DONE));
    assign mem_wdata_o  = ~w_out_en ? '0 :
                          w_is_load ? {{DATA_W{1'b0}}, r_rdata_q} : ex_wdata_i;

    assign stall_req_o  = w_out_en & w_stall;
    assign adel_o       = w_out_en & w_is_load & w_misaligned;
    assign ades_o       = w_out_en & w_is_store & w_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Directed self-checking bench for mem_access_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam logic [3:0] c_NONE = 4'd0;
    localparam logic [3:0] c_LB   = 4'd1;
    localparam logic [3:0] c_LBU  = 4'd2;
    localparam logic [3:0] c_LH   = 4'd3;
    localparam logic [3:0] c_LHU  = 4'd4;
    localparam logic [3:0] c_LW   = 4'd5;
    localparam logic [3:0] c_SB   = 4'd6;
    localparam logic [3:0] c_SH   = 4'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [63:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_memaddr;
    logic [31:0] ex_storedata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [63:0] mem_wdata;
    logic        stall_req, adel, ades;

    int errors = 0;
    int checks = 0;

    mem_access_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .ex_wd_i        (ex_wd),
        .ex_wreg_i      (ex_wreg),
        .ex_wdata_i     (ex_wdata),
        .ex_memop_i     (ex_memop),
        .ex_memaddr_i   (ex_memaddr),
        .ex_storedata_i (ex_storedata),
        .data_req_o     (data_req),
        .data_wr_o      (data_wr),
        .data_size_o    (data_size),
        .data_addr_o    (data_addr),
        .data_wdata_o   (data_wdata),
        .data_addr_ok_i (data_addr_ok),
        .data_data_ok_i (data_data_ok),
        .data_rdata_i   (data_rdata),
        .mem_wd_o       (mem_wd),
        .mem_wreg_o     (mem_wreg),
        .mem_wdata_o    (mem_wdata),
        .stall_req_o    (stall_req),
        .adel_o         (adel),
        .ades_o         (ades)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        stall = 1'b0; flush = 1'b0;
        ex_memop = c_NONE; ex_wreg = 1'b0; ex_wd = 5'd0; ex_wdata = 64'd0;
        ex_memaddr = 32'd0; ex_storedata = 32'd0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    endtask

    // Load with addr_ok in the request cycle and data_ok on the next one.
    task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        ex_memop = op; ex_memaddr = addr; ex_wd = 5'd7; ex_wreg = 1'b1;
        data_addr_ok = 1'b1;
        #1;
        chk({tag, "_req"}, data_req, 1);
        chk({tag, "_wreg_bubble"}, mem_wreg, 0);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata;
        #1;
        chk({tag, "_stall_data"}, stall_req, 1);
        next_cycle();
        data_data_ok = 1'b0; data_rdata = 32'd0;
        #1;
        chk({tag, "_stall_done"}, stall_req, 0);
        chk({tag, "_wreg"}, mem_wreg, 1);
        chk({tag, "_wdata"}, mem_wdata, {32'd0, exp});
        next_cycle();
        bus_idle();
        #1;
    endtask

    initial begin
        // ------------------------------------------------------------ reset
        rst = 1'b1;
        bus_idle();
        ex_memop = c_LW; ex_wreg = 1'b1; ex_wd = 5'd9; ex_wdata = 64'h1;
        ex_memaddr = 32'h1000; data_addr_ok = 1'b1;
        #12;
        chk("rst_req", data_req, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_wreg", mem_wreg, 0);
        chk("rst_wd", mem_wd, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        next_cycle();
        rst = 1'b0;
        bus_idle();
        #1;

        // ------------------------------------------------ non-memory pass-through
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 64'h12345678_9ABCDEF0;
        #1;
        chk("pass_wdata", mem_wdata, 64'h12345678_9ABCDEF0);
        chk("pass_wreg", mem_wreg, 1);
        chk("pass_wd", mem_wd, 5);
        chk("pass_stall", stall_req, 0);
        chk("pass_req", data_req, 0);
        next_cycle();
        bus_idle();

        // --------------------------- LW 0x1000, addr_ok now, data_ok 2 cycles later
        ex_memop = c_LW; ex_memaddr = 32'h1000; ex_wd = 5'd3; ex_wreg = 1'b1;
        ex_wdata = 64'hFFFF; data_addr_ok = 1'b1;
        #1;
        chk("lw_req", data_req, 1);
        chk("lw_wr", data_wr, 0);
        chk("lw_size", data_size, 2);
        chk("lw_addr", data_addr, 32'h1000);
        chk("lw_stall0", stall_req, 1);
        chk("lw_wreg0", mem_wreg, 0);
        chk("lw_rdataq_reset", mem_wdata, 0);
        next_cycle();
        data_addr_ok = 1'b0;
        #1;
        chk("lw_req1", data_req, 0);
        chk("lw_stall1", stall_req, 1);
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        #1;
        chk("lw_stall2", stall_req, 1);
        chk("lw_wreg2", mem_wreg, 0);
        next_cycle();
        data_data_ok = 1'b0; data_rdata = 32'd0;
        #1;
        chk("lw_stall3", stall_req, 0);
        chk("lw_wreg3", mem_wreg, 1);
        chk("lw_wd3", mem_wd, 3);
        chk("lw_wdata3", mem_wdata, 64'h00000000_DEADBEEF);
        next_cycle();
        bus_idle();
        #1;

        // --------------------------------------------------- load extraction
        do_load("lb3",  c_LB,  32'h1003, 32'h80112233, 32'hFFFFFF80);
        do_load("lbu3", c_LBU, 32'h1003, 32'h80112233, 32'h00000080);
        do_load("lb1",  c_LB,  32'h1001, 32'h80112233, 32'h00000022);
        do_load("lh2",  c_LH,  32'h1002, 32'h80112233, 32'hFFFF8011);
        do_load("lhu0", c_LHU, 32'h1000, 32'h80112233, 32'h00002233);

        // ------------------------------------------------------ misalignment
        ex_memop = c_SH; ex_memaddr = 32'h1001; ex_wreg = 1'b1; ex_storedata = 32'h1234;
        data_addr_ok = 1'b1;
        #1;
        chk("sh_mis_ades", ades, 1);
        chk("sh_mis_adel", adel, 0);
        chk("sh_mis_req", data_req, 0);
        chk("sh_mis_wreg", mem_wreg, 0);
        chk("sh_mis_stall", stall_req, 0);
        next_cycle();
        #1;
        chk("sh_mis_req_next", data_req, 0);
        ex_memop = c_LW; ex_memaddr = 32'h1002;
        #1;
        chk("lw_mis_adel", adel, 1);
        chk("lw_mis_ades", ades, 0);
        chk("lw_mis_req", data_req, 0);
        next_cycle();
        bus_idle();
        #1;

        // ------------------------------------------- SB with addr_ok delayed 3 cycles
        ex_memop = c_SB; ex_memaddr = 32'h2002; ex_storedata = 32'h000000A5;
        ex_wdata = 64'hCAFE;
        for (int k = 0; k < 4; k++) begin
            data_addr_ok = (k == 3);
            #1;
            chk("sb_req", data_req, 1);
            chk("sb_addr", data_addr, 32'h2002);
            chk("sb_wdata", data_wdata, 32'hA5A5A5A5);
            chk("sb_size", data_size, 0);
            chk("sb_wr", data_wr, 1);
            chk("sb_stall", stall_req, 1);
            next_cycle();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        #1;
        chk("sb_data_req", data_req, 0);
        chk("sb_data_stall", stall_req, 1);
        next_cycle();
        data_data_ok = 1'b0;
        #1;
        chk("sb_done_stall", stall_req, 0);
        chk("sb_done_wreg", mem_wreg, 0);
        chk("sb_done_wdata", mem_wdata, 64'hCAFE);
        next_cycle();
        bus_idle();
        #1;

        // ------------------------------------------------- LW flushed in DATA
        ex_memop = c_LW; ex_memaddr = 32'h4000; ex_wreg = 1'b1; data_addr_ok = 1'b1;
        #1;
        chk("fl_req", data_req, 1);
        next_cycle();
        data_addr_ok = 1'b0; flush = 1'b1;
        #1;
        chk("fl_data_wreg", mem_wreg, 0);
        chk("fl_data_stall", stall_req, 1);
        next_cycle();
        flush = 1'b0;
        #1;
        chk("fl_cancel_stall", stall_req, 1);
        chk("fl_cancel_req", data_req, 0);
        chk("fl_cancel_wreg", mem_wreg, 0);
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'h55555555;
        #1;
        chk("fl_cancel_stall2", stall_req, 1);
        chk("fl_cancel_wreg2", mem_wreg, 0);
        next_cycle();
        bus_idle();
        #1;
        chk("fl_idle_stall", stall_req, 0);
        chk("fl_idle_req", data_req, 0);

        // -------------------------------------- LW held in DONE by downstream stall
        ex_memop = c_LW; ex_memaddr = 32'h3000; ex_wd = 5'd12; ex_wreg = 1'b1;
        data_addr_ok = 1'b1;
        #1;
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h11223344;
        next_cycle();
        data_data_ok = 1'b0; data_rdata = 32'd0; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_stall", stall_req, 0);
            chk("hold_req", data_req, 0);
            chk("hold_wreg", mem_wreg, 1);
            chk("hold_wdata", mem_wdata, 64'h00000000_11223344);
            next_cycle();
        end
        stall = 1'b0;
        #1;
        chk("rel_wreg", mem_wreg, 1);
        chk("rel_req", data_req, 0);
        next_cycle();
        // Back in IDLE: the still-present LW issues a fresh request.
        #1;
        chk("rel_idle_req", data_req, 1);
        chk("rel_idle_wreg", mem_wreg, 0);
        next_cycle();
        // Now in ADDR: a flush suppresses the request and returns to IDLE.
        flush = 1'b1;
        #1;
        chk("addr_flush_req", data_req, 0);
        next_cycle();
        bus_idle();
        #1;
        chk("addr_flush_idle", stall_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
